// File: rtl/input_conditioner.sv
// Board input front end: per-channel two-flop synchroniser, debounce FSM,
// registered clean level and single-cycle rise/fall pulses.
module input_conditioner #(
   parameter int                  N_INPUTS      = 3,
   parameter int                  STABLE_CYCLES = 65536,
   parameter logic [N_INPUTS-1:0] INIT_LEVEL    = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_INPUTS-1:0] raw_in,
   output logic [N_INPUTS-1:0] level,
   output logic [N_INPUTS-1:0] rise,
   output logic [N_INPUTS-1:0] fall
);

   localparam int CW = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);

   typedef enum logic [1:0] {
      ST_LOW,
      ST_WAIT_H,
      ST_HIGH,
      ST_WAIT_L
   } state_t;

   genvar g;
   generate
      for (g = 0; g < N_INPUTS; g++) begin : g_ch
         localparam state_t RST_ST = INIT_LEVEL[g] ? ST_HIGH : ST_LOW;

         logic          r_sync1;
         logic          r_sync2;
         state_t        r_state;
         state_t        w_next;
         logic [CW-1:0] r_cnt;
         logic [CW-1:0] w_cnt_nxt;
         logic          r_level;
         logic          r_rise;
         logic          r_fall;
         logic          w_level_nxt;
         logic          w_rise_nxt;
         logic          w_fall_nxt;
         logic          w_cnt_done;
         logic          w_waiting;

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_sync1 <= INIT_LEVEL[g];
               r_sync2 <= INIT_LEVEL[g];
            end else begin
               r_sync1 <= raw_in[g];
               r_sync2 <= r_sync1;
            end
         end

         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               r_state <= RST_ST;
               r_cnt   <= '0;
               r_level <= INIT_LEVEL[g];
               r_rise  <= 1'b0;
               r_fall  <= 1'b0;
            end else begin
               r_state <= w_next;
               r_cnt   <= w_cnt_nxt;
               r_level <= w_level_nxt;
               r_rise  <= w_rise_nxt;
               r_fall  <= w_fall_nxt;
            end
         end

         assign w_cnt_done = (r_cnt == CNT_MAX);

         always_comb begin
            w_next = r_state;
            unique case (r_state)
               ST_LOW: begin
                  if (r_sync2) w_next = ST_WAIT_H;
               end
               ST_WAIT_H: begin
                  if (!r_sync2)       w_next = ST_LOW;
                  else if (w_cnt_done) w_next = ST_HIGH;
               end
               ST_HIGH: begin
                  if (!r_sync2) w_next = ST_WAIT_L;
               end
               ST_WAIT_L: begin
                  if (r_sync2)        w_next = ST_HIGH;
                  else if (w_cnt_done) w_next = ST_LOW;
               end
               default: w_next = RST_ST;
            endcase
         end

         // Counter only advances while staying in a WAIT state; any exit clears it.
         assign w_waiting = (r_state == ST_WAIT_H) || (r_state == ST_WAIT_L);

         always_comb begin
            w_cnt_nxt   = '0;
            w_level_nxt = (w_next == ST_HIGH) || (w_next == ST_WAIT_L);
            w_rise_nxt  = (r_state == ST_WAIT_H) && (w_next == ST_HIGH);
            w_fall_nxt  = (r_state == ST_WAIT_L) && (w_next == ST_LOW);
            if (w_waiting && (w_next == r_state))
               w_cnt_nxt = r_cnt + CNT_ONE;
         end

         assign level[g] = r_level;
         assign rise[g]  = r_rise;
         assign fall[g]  = r_fall;
      end
   endgenerate

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: two instances (init 000 / 111) checked every
// cycle against a run-length debounce model, plus directed scenario checks.
module tb_input_conditioner;

   localparam int S = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] raw_in = 3'b111;

   logic [2:0] level0, rise0, fall0;
   logic [2:0] level1, rise1, fall1;

   int n_cmp = 0;
   int n_bad = 0;

   // model state: [instance] packed per channel
   logic [2:0] m_lvl [2];
   logic [2:0] m_rise[2];
   logic [2:0] m_fall[2];
   logic [2:0] m_hist0[2];
   logic [2:0] m_hist1[2];
   int         m_run [2][3];

   int n_rise[3];
   int n_fall[3];

   always #5 clk = ~clk;

   input_conditioner #(
      .N_INPUTS(3), .STABLE_CYCLES(S), .INIT_LEVEL(3'b000)
   ) dut0 (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .level(level0), .rise(rise0), .fall(fall0)
   );

   input_conditioner #(
      .N_INPUTS(3), .STABLE_CYCLES(S), .INIT_LEVEL(3'b111)
   ) dut1 (
      .clk(clk), .reset(reset), .raw_in(raw_in),
      .level(level1), .rise(rise1), .fall(fall1)
   );

   function automatic logic [2:0] init_of(input int k);
      return (k == 0) ? 3'b000 : 3'b111;
   endfunction

   task automatic chk(input string tag, input logic [2:0] o, input logic [2:0] e);
      n_cmp++;
      assert (o === e) else begin
         n_bad++;
         $error("FAIL %s observed=%b expected=%b t=%0t", tag, o, e, $time);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_lvl[k]   = init_of(k);
         m_hist0[k] = init_of(k);
         m_hist1[k] = init_of(k);
         m_rise[k]  = '0;
         m_fall[k]  = '0;
         for (int c = 0; c < 3; c++) m_run[k][c] = 0;
      end
   endtask

   // A new value is accepted after S+1 consecutive synchronised samples
   // that differ from the current level; the sample seen is raw from two edges ago.
   task automatic model_edge(input logic [2:0] r);
      for (int k = 0; k < 2; k++) begin
         m_rise[k] = '0;
         m_fall[k] = '0;
         for (int c = 0; c < 3; c++) begin
            if (m_hist1[k][c] != m_lvl[k][c]) m_run[k][c]++;
            else m_run[k][c] = 0;
            if (m_run[k][c] == S + 1) begin
               m_lvl[k][c] = ~m_lvl[k][c];
               if (m_lvl[k][c]) m_rise[k][c] = 1'b1;
               else m_fall[k][c] = 1'b1;
               m_run[k][c] = 0;
            end
         end
         m_hist1[k] = m_hist0[k];
         m_hist0[k] = r;
      end
   endtask

   task automatic check_all();
      chk("lvl0", level0, m_lvl[0]);
      chk("rise0", rise0, m_rise[0]);
      chk("fall0", fall0, m_fall[0]);
      chk("lvl1", level1, m_lvl[1]);
      chk("rise1", rise1, m_rise[1]);
      chk("fall1", fall1, m_fall[1]);
      chk("excl0", rise0 & fall0, 3'b000);
      chk("excl1", rise1 & fall1, 3'b000);
   endtask

   task automatic clr_counts();
      for (int c = 0; c < 3; c++) begin
         n_rise[c] = 0;
         n_fall[c] = 0;
      end
   endtask

   task automatic tick(input logic [2:0] r);
      raw_in = r;
      @(posedge clk);
      model_edge(r);
      #1;
      check_all();
      for (int c = 0; c < 3; c++) begin
         n_rise[c] += int'(rise0[c]);
         n_fall[c] += int'(fall0[c]);
      end
   endtask

   task automatic do_reset(input logic [2:0] r, input int cycles);
      raw_in = r;
      reset  = 1'b1;
      model_reset();
      repeat (cycles) begin
         @(posedge clk);
         #1;
         chk("rst_lvl0", level0, 3'b000);
         chk("rst_pulse0", rise0 | fall0, 3'b000);
         chk("rst_lvl1", level1, 3'b111);
         chk("rst_pulse1", rise1 | fall1, 3'b000);
      end
   endtask

   task automatic release_reset(input logic [2:0] r);
      raw_in = r;
      reset  = 1'b0;
   endtask

   initial begin
      logic [2:0] r;
      #2;
      // reset values with raw high throughout
      do_reset(3'b111, 4);

      // clean press on channel 0
      release_reset(3'b000);
      clr_counts();
      for (int e = 1; e <= 10; e++) tick(3'b001);
      chk("press_pre", rise0, 3'b000);
      tick(3'b001);
      chk("press_rise11", rise0, 3'b001);
      chk("press_lvl11", level0, 3'b001);
      tick(3'b001);
      chk("press_rise12", rise0, 3'b000);
      chk("press_lvl12", level0, 3'b001);

      // glitch on channel 1
      clr_counts();
      repeat (5) tick(3'b011);
      repeat (20) tick(3'b001);
      chk("glitch_lvl", level0, 3'b001);
      chk("glitch_pulses", 3'(n_rise[1] + n_fall[1]), 3'd0);

      // bounce on channel 2
      clr_counts();
      tick(3'b101);
      tick(3'b001);
      tick(3'b101);
      tick(3'b001);
      for (int e = 1; e <= 10; e++) tick(3'b101);
      chk("bounce_early", 3'(n_rise[2]), 3'd0);
      tick(3'b101);
      chk("bounce_rise11", rise0, 3'b100);
      repeat (5) tick(3'b101);
      chk("bounce_count", 3'(n_rise[2]), 3'd1);

      // all channels high, then simultaneous release
      repeat (14) tick(3'b111);
      chk("all_high", level0, 3'b111);
      for (int e = 1; e <= 10; e++) tick(3'b000);
      chk("drop_pre", fall0, 3'b000);
      tick(3'b000);
      chk("drop_fall11", fall0, 3'b111);
      chk("drop_lvl11", level0, 3'b000);
      chk("drop_fall1_11", fall1, 3'b111);
      tick(3'b000);
      chk("drop_fall12", fall0, 3'b000);

      // reset in the middle of a WAIT
      clr_counts();
      repeat (6) tick(3'b001);
      chk("midwait_nopulse", 3'(n_rise[0]), 3'd0);
      do_reset(3'b001, 2);
      release_reset(3'b001);
      tick(3'b001);
      chk("init111_after", level1, 3'b111);
      for (int e = 2; e <= 10; e++) tick(3'b001);
      chk("midwait_pre", rise0, 3'b000);
      tick(3'b001);
      chk("midwait_rise11", rise0, 3'b001);

      // randomised: slow level changes with bursts of bounce and rare resets
      r = 3'b000;
      for (int i = 0; i < 1500; i++) begin
         for (int c = 0; c < 3; c++) begin
            if ($urandom_range(0, 15) == 0) r[c] = ~r[c];
         end
         if ($urandom_range(0, 299) == 0) begin
            do_reset(r, $urandom_range(1, 3));
            release_reset(r);
         end
         tick(r);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/input_conditioner.md
Name: input_conditioner

Overview:
- Board-level input front end. Sits directly upstream of the processor core on the Arty S7-50.
- Takes the raw asynchronous buttons and slide switch: btn[1] (main reset), btn[0] (core/RAM reset) and sw (loading).
- For each channel it synchronises, debounces, and produces a clean level plus single-cycle rise/fall pulses.
- The top level drives the processor's reset and loading inputs from level/rise rather than from raw pins.

Parameters:
- N_INPUTS, 3, number of independent channels; bit order {sw, btn[1], btn[0]} at top level.
- STABLE_CYCLES, 65536, consecutive clk cycles the synchronised input must hold a new value before it is accepted. Must be >= 1. At 12 MHz, 65536 ≈ 5.5 ms.
- INIT_LEVEL, 0, N_INPUTS-bit vector giving the per-channel level after reset.

Ports:
- clk, input, 1, system clock (CLK12MHZ domain).
- reset, input, 1, asynchronous, active-high; clears all state.
- raw_in, input, N_INPUTS, raw pin values; asynchronous to clk.
- level, output, N_INPUTS, debounced stable value per channel.
- rise, output, N_INPUTS, 1-cycle pulse when level goes 0->1.
- fall, output, N_INPUTS, 1-cycle pulse when level goes 1->0.

Behaviour:
- Per-channel logic is identical and independent (generate loop). There is no cross-channel interaction.
- Synchroniser: two flops per channel (sync1, sync2), both reset to INIT_LEVEL[i]. Downstream logic sees only sync2.
- Counter: width $clog2(STABLE_CYCLES) (minimum 1), unsigned. Reset value 0. It never wraps, because it is cleared on every state exit.
- FSM per channel: four states.
  - Reset state is STABLE_HIGH if INIT_LEVEL[i]=1, else STABLE_LOW.
  - STABLE_LOW: sync2=1 -> WAIT_HIGH, cnt<=0; else stay.
  - WAIT_HIGH: sync2=0 -> STABLE_LOW, cnt<=0 (glitch rejected, no output change). Else if cnt==STABLE_CYCLES-1 -> STABLE_HIGH, level<=1, rise<=1. Else cnt<=cnt+1.
  - STABLE_HIGH: sync2=0 -> WAIT_LOW, cnt<=0; else stay.
  - WAIT_LOW: mirror of WAIT_HIGH. Accepting leads to STABLE_LOW, level<=0, fall<=1.
- Outputs are registered.
  - level reflects current stable state: 1 in STABLE_HIGH and WAIT_LOW, 0 otherwise.
  - rise/fall are high for exactly one cycle, coincident with the level change. Default 0 every other cycle.
- Latency:
  - Setup: raw_in changes and settles before clk edge 1, then stays stable.
  - level, and the matching pulse, update on edge STABLE_CYCLES+3.
  - Edges 1-2 are the synchroniser, edge 3 enters WAIT, and edges 4..STABLE_CYCLES+3 count.
- Bounce handling: any return of sync2 to the old value during WAIT resets the count. Acceptance therefore requires STABLE_CYCLES+1 consecutive sampled cycles at the new value (entry cycle plus count).
- Reset values:
  - level = INIT_LEVEL.
  - rise = 0, fall = 0.
  - cnt = 0.
  - sync1 = sync2 = INIT_LEVEL.
- Reset mid-operation:
  - Any WAIT progress is discarded and no pulse is emitted.
  - After release, if the pin differs from INIT_LEVEL, the full latency applies from the first edge.
- rise and fall for the same channel are never high in the same cycle. At most one of them is high per channel per cycle.
- No combinational path from raw_in to any output.

Test Plan:
- Reset values: N_INPUTS=3, STABLE_CYCLES=8, INIT_LEVEL=3'b000. Assert reset, hold raw_in=3'b111 throughout reset -> level=000, rise=000, fall=000 while reset is high.
- Clean press: same config. Release reset, then raw_in[0] 0->1 before edge 1 and held -> level[0]=1 and rise[0]=1 at edge 11. rise[0]=0 at edge 12. Channels 1-2 unchanged.
- Glitch rejection: raw_in[1] high for 5 cycles then low -> level[1] stays 0, no rise/fall pulses ever.
- Bounce:
  - Stimulus: raw_in[2] toggles 1,0,1,0 on alternate cycles, then holds 1.
  - Required: exactly one rise[2] pulse, at edge 11 after the final 0->1 settle. Zero pulses during the bouncing.
- Release and simultaneous channels:
  - Setup: all channels at level 1.
  - Stimulus: drop raw_in=000 on the same cycle.
  - Required: fall=111 for one cycle at edge 11 and level=000. Repeat with INIT_LEVEL=3'b111 and confirm level=111 immediately after reset.
- Reset mid-WAIT: raw_in[0]=1 for 6 cycles, then assert reset for 2 cycles, then release with raw_in[0] still 1 -> no pulse before reset. rise[0] is asserted 11 edges after release.
